serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement/unsigned subtractor computing diff = a - b, LSB first, one bit per clock.
- Built around a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation companion to the team's switch-level full-adder cell.
- Intended as the arithmetic engine for small sequential datapaths where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk in IDLE or DONE.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse: diff/borrow_out valid.
- diff  output  WIDTH  result a - b mod 2^WIDTH; held until next accepted start.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned; held with diff.

Behaviour:
Reset:
- rst_n low asynchronously forces state=IDLE and busy=0, done=0, diff=0, borrow_out=0.
- Internal shift registers, borrow FF and counter are cleared.
- Reset asserted mid-RUN aborts the operation. No done is produced and nothing partial is retained.

States:
- IDLE -> RUN: on start=1. Load sa<=a, sb<=b, borrow<=0, cnt<=0, diff<=0.
- RUN: each edge does the following.
  - Compute d = sa[0]^sb[0]^borrow and bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow).
  - Update diff <= {d, diff[WIDTH-1:1]}, borrow <= bo, sa>>=1, sb>>=1, cnt<=cnt+1.
  - When cnt==WIDTH-1 on that edge, go to DONE and register borrow_out<=bo.
- DONE: done=1 for exactly this cycle.
  - start=1 is accepted: same load as IDLE, go to RUN.
  - Otherwise go to IDLE.

Handshake and timing:
- busy=1 exactly in RUN.
- start while in RUN is ignored; no queuing.
- Latency: start sampled at edge E0 → done high in the cycle following edge E0+WIDTH.
- Back-to-back operations (start held or pulsed in DONE) therefore run at WIDTH+1 cycles per result.
- diff and borrow_out are stable from the done cycle until the edge that accepts the next start. On that edge diff clears to 0.
- WIDTH=1: RUN lasts one edge; done follows E0+1.

Arithmetic:
- Purely modulo 2^WIDTH, no saturation.
- Signed overflow is not reported. The caller derives it from operand MSBs and diff MSB if needed.

Decomposition:
- Package serial_sub_pkg holds:
  - state_t enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Constant SUB_DEFAULT_WIDTH = 8.
- Sub-module full_subtractor (inputs x, y, bin; outputs d, bout) is a combinational cell instantiated once.
  - Gate-level with the same primitive-delay style as the team's adder cells, so it can also be reused in ripple subtractors.
- All sequential logic lives in serial_subtractor.

Test Plan:
- WIDTH=8, a=100, b=37, start pulse → busy 8 cycles, done pulse at E0+8, diff=63, borrow_out=0.
- a=0, b=1 → diff=255, borrow_out=1. Also a=255, b=255 → diff=0, borrow_out=0.
- start held high during RUN with different a/b → ignored. Result matches the originally captured operands.
- start=1 in the DONE cycle with a=5, b=9 → immediate new RUN, no idle gap. Second done 9 cycles after the first, diff=252, borrow_out=1.
- rst_n pulsed low at cycle 4 of RUN → all outputs 0 immediately (asynchronous), no done. A fresh start afterwards computes correctly.
- Exhaustive sweep for WIDTH=4 (all 256 a/b pairs) checks diff and borrow_out against a-b. WIDTH=1 smoke test: 0-1 → diff=1, borrow_out=1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    // Controller states; the 2-bit encoding is also visible on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand width used when the instantiating block does not override it.
    localparam int SUB_DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
// Built from gate primitives so the same cell drops into ripple subtractors.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    wire w_x_xor_y;
    wire w_x_n;
    wire w_xy_same;
    wire w_gen;
    wire w_prop;

    // Difference bit: parity of the three inputs.
    xor g_xor0 (w_x_xor_y, x, y);
    xor g_xor1 (d, w_x_xor_y, bin);

    // Borrow is generated when x=0,y=1, and propagated when x==y.
    not g_not0 (w_x_n, x);
    and g_and0 (w_gen, w_x_n, y);
    not g_not1 (w_xy_same, w_x_xor_y);
    and g_and1 (w_prop, w_xy_same, bin);
    or  g_or0  (bout, w_gen, w_prop);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock,
// using a single full-subtractor cell plus a borrow flip-flop.
//
// Handshake: start is sampled on a rising edge only in IDLE or DONE; when
// sampled high, a and b are captured and the operation begins (busy=1 for
// exactly WIDTH cycles). done is a one-cycle pulse during which diff and
// borrow_out are valid; they stay stable until the edge that accepts the next
// start. start seen while busy is ignored and never queued.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_bo;
    logic [WIDTH:0]   w_diff_cat;
    logic [WIDTH-1:0] w_diff_next;

    // The only arithmetic in the design: one bit of a - b per clock.
    full_subtractor u_fs (
        .x    (r_sa[0]),
        .y    (r_sb[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bo)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
    // Concatenate-then-slice keeps this legal for WIDTH=1.
    always_comb begin
        w_diff_cat  = {w_d, r_diff};
        w_diff_next = w_diff_cat[WIDTH:1];
    end

    // Controller, operand shifters, borrow FF and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sa         <= '0;
            r_sb         <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_diff   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bo;
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_borrow_out <= w_bo;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign dbg_state  = r_state;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8, 4 and 1 with a queue-based scoreboard.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic       start8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic [1:0] st8;
  logic       start4, busy4, done4, bo4;
  logic [3:0] a4, b4, diff4;
  logic [1:0] st4;
  logic       start1, busy1, done1, bo1;
  logic [0:0] a1, b1, diff1;
  logic [1:0] st1;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .dbg_state(st8)
  );
  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4), .dbg_state(st4)
  );
  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];
  logic [1:0] exp1_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer subtraction, reduced mod 2^w; borrow iff a < b.
  function automatic longint ref_sub(input longint a, input longint b, input int w);
    longint m;
    m = longint'(1) << w;
    return ((a < b) ? m : 0) + ((a - b + m) % m);
  endfunction

  always @(negedge clk) begin
    if (rst_n && done8 === 1'b1) begin
      if (exp8_q.size() == 0) check("w8 unexpected done", 32'd1, 32'd0);
      else begin
        logic [8:0] e;
        e = exp8_q.pop_front();
        check("w8 diff", 32'(diff8), 32'(e[7:0]));
        check("w8 borrow_out", 32'(bo8), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4 === 1'b1) begin
      if (exp4_q.size() == 0) check("w4 unexpected done", 32'd1, 32'd0);
      else begin
        logic [4:0] e;
        e = exp4_q.pop_front();
        check("w4 diff", 32'(diff4), 32'(e[3:0]));
        check("w4 borrow_out", 32'(bo4), 32'(e[4]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1 === 1'b1) begin
      if (exp1_q.size() == 0) check("w1 unexpected done", 32'd1, 32'd0);
      else begin
        logic [1:0] e;
        e = exp1_q.pop_front();
        check("w1 diff", 32'(diff1), 32'(e[0]));
        check("w1 borrow_out", 32'(bo1), 32'(e[1]));
      end
    end
  end

  // ---------------- drivers ----------------
  // Present operands with start for one accepting edge (E0); returns at E0+1ns.
  task automatic go8(input int a, input int b, input bit push);
    @(posedge clk); #1;
    a8 = 8'(a); b8 = 8'(b); start8 = 1'b1;
    if (push) exp8_q.push_back(9'(ref_sub(a, b, 8)));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Counts cycles until done is seen (1 = cycle right after the last edge).
  task automatic wait_done8(output int cyc, output int busy_cyc);
    bit seen;
    cyc = 0; busy_cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy8 === 1'b1) busy_cyc++;
      if (done8 === 1'b1) seen = 1;
    end
    if (!seen) check("w8 done timeout", 32'd0, 32'd1);
  endtask

  task automatic run4(input int a, input int b);
    int n;
    @(posedge clk); #1;
    a4 = 4'(a); b4 = 4'(b); start4 = 1'b1;
    exp4_q.push_back(5'(ref_sub(a, b, 4)));
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done4 !== 1'b1 && n < 50);
    if (done4 !== 1'b1) check("w4 done timeout", 32'd0, 32'd1);
  endtask

  task automatic run1(input int a, input int b);
    int n;
    @(posedge clk); #1;
    a1 = 1'(a); b1 = 1'(b); start1 = 1'b1;
    exp1_q.push_back(2'(ref_sub(a, b, 1)));
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done1 !== 1'b1 && n < 50);
    if (done1 !== 1'b1) check("w1 done timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c, bc;
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0;
    start4 = 0; a4 = 0; b4 = 0;
    start1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    check("reset diff", 32'(diff8), 32'd0);
    check("reset borrow_out", 32'(bo8), 32'd0);
    check("reset busy", 32'(busy8), 32'd0);
    check("reset done", 32'(done8), 32'd0);
    check("reset state", 32'(st8), 32'(IDLE));
    check("reset w4 state", 32'(st4), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic: 100 - 37, latency and busy length.
    go8(100, 37, 1);
    wait_done8(c, bc);
    check("w8 latency", 32'(c), 32'd9);
    check("w8 busy cycles", 32'(bc), 32'd8);
    @(negedge clk);
    check("w8 done one cycle", 32'(done8), 32'd0);
    check("w8 diff held", 32'(diff8), 32'd63);

    // Boundaries.
    go8(0, 1, 1);
    wait_done8(c, bc);
    go8(255, 255, 1);
    wait_done8(c, bc);

    // start held during RUN with changing operands: ignored.
    @(posedge clk); #1;
    a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
    exp8_q.push_back(9'(ref_sub(10, 3, 8)));
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    start8 = 1'b0;
    wait_done8(c, bc);

    // Back-to-back: start raised during the DONE cycle.
    go8(200, 13, 1);
    wait_done8(c, bc);
    a8 = 8'd5; b8 = 8'd9; start8 = 1'b1;
    exp8_q.push_back(9'(ref_sub(5, 9, 8)));
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(c, bc);
    check("w8 back-to-back gap", 32'(c), 32'd9);

    // Reset in the middle of RUN: aborted, nothing expected.
    go8(77, 22, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort diff", 32'(diff8), 32'd0);
    check("abort borrow_out", 32'(bo8), 32'd0);
    check("abort busy", 32'(busy8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post-abort state", 32'(st8), 32'(IDLE));
    go8(150, 151, 1);
    wait_done8(c, bc);

    // Random operands.
    for (int i = 0; i < 20; i++) begin
      go8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
      wait_done8(c, bc);
    end

    // Exhaustive WIDTH=4.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run4(x, y);

    // WIDTH=1 smoke (all pairs, including 0-1).
    run1(0, 1);
    run1(1, 0);
    run1(1, 1);
    run1(0, 0);

    @(negedge clk);
    @(negedge clk);
    check("w8 queue drained", 32'(exp8_q.size()), 32'd0);
    check("w4 queue drained", 32'(exp4_q.size()), 32'd0);
    check("w1 queue drained", 32'(exp1_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_subtractor
